cbd_sample_scheduler: RTL and testbench

Sequences the CBD small-polynomial sampler through the full batch of noise polynomials for one Kyber operation. For KeyGen the batch is s and e; for Encrypt it is r, e1 and e2. For each polynomial the block builds the seed||nonce message, picks eta, and resets, fires and waits on the sampler. Each result lands in its own 32-word slot of the coefficient RAM. It sits between the top-level Kyber FSM and the sampler, and is the sampler's only driver.

---
 rtl/cbd_sample_scheduler_if.sv | 37 +++
 rtl/cbd_sample_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_cbd_sample_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_sample_scheduler_if.sv
// ----------------------------------------------------------------------------
// cbd_sample_scheduler_if
// Bundle between the CBD sample scheduler and the CBD small-polynomial sampler.
//   smp_M      : 264-bit sampler message, seed in [255:0], nonce in [263:256]
//   smp_n_num  : eta code, 1 = eta 3, 2 = eta 2
//   smp_offset : coefficient RAM start word for the polynomial
//   smp_active : sampler fire/hold
//   smp_rst    : sampler local reset
//   smp_done   : sampler finished flag (level)
// Modports: master = scheduler side, slave = sampler side.
// ----------------------------------------------------------------------------
interface cbd_sample_scheduler_if;
    logic [263:0] smp_M;
    logic [1:0]   smp_n_num;
    logic [9:0]   smp_offset;
    logic         smp_active;
    logic         smp_rst;
    logic         smp_done;

    modport master (
        output smp_M,
        output smp_n_num,
        output smp_offset,
        output smp_active,
        output smp_rst,
        input  smp_done
    );

    modport slave (
        input  smp_M,
        input  smp_n_num,
        input  smp_offset,
        input  smp_active,
        input  smp_rst,
        output smp_done
    );
endinterface

// File: rtl/cbd_sample_scheduler.sv
// ----------------------------------------------------------------------------
// cbd_sample_scheduler
// Walks the CBD sampler through every noise polynomial of one Kyber operation
// (KeyGen: 2k polys, Encrypt: 2k+1 polys). For each polynomial it builds the
// seed||nonce message, selects eta, picks the RAM slot, then resets, fires and
// waits on the sampler.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle batch request (honoured only in IDLE, legal k)
//   mode          : 0 = KeyGen, 1 = Encrypt
//   k             : module rank (2, 3 or 4)
//   eta1_is3      : 1 = eta1 is 3, 0 = eta1 is 2
//   seed          : 256-bit seed, captured at start
//   nonce_base    : nonce of polynomial 0, captured at start
//   smp           : sampler bundle (master side)
//   busy          : batch in progress
//   done          : one-cycle pulse at batch end
//   poly_idx      : index of the polynomial in flight
//   err           : sticky watchdog flag
//
// Optional build macro CBD_SCHED_TIMEOUT_EN: adds a per-polynomial watchdog of
// TIMEOUT_CYCLES WAIT cycles; on expiry err is set and the batch ends early.
// Without it WAIT has no bound and err is constant 0.
// ----------------------------------------------------------------------------
module cbd_sample_scheduler #(
    parameter int BASE_ADDR      = 0,
    parameter int SLOT_WORDS     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [2:0]             k,
    input  logic                   eta1_is3,
    input  logic [255:0]           seed,
    input  logic [7:0]             nonce_base,
    cbd_sample_scheduler_if.master smp,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             poly_idx,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FIRE,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t         state_q, state_d;
    logic [3:0]     p_q, p_d;
    logic           mode_q, mode_d;
    logic [2:0]     k_q, k_d;
    logic           eta3_q, eta3_d;
    logic [255:0]   seed_q, seed_d;
    logic [7:0]     nb_q, nb_d;

    logic           k_legal;
    logic           accept;
    logic [3:0]     last_p;

    logic           smp_rst_d, smp_active_d, busy_d, done_d;
    logic [263:0]   smp_M_d;
    logic [1:0]     n_num_d;
    logic [9:0]     offset_d;

`ifdef CBD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Encrypt polys at index >= k are e1/e2 and always use eta2 = 2.
    function automatic logic [1:0] eta_code(input logic m, input logic [2:0] kk,
                                            input logic e3, input logic [3:0] p);
        if (m && (p >= {1'b0, kk}))
            return 2'd2;
        return e3 ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [9:0] slot_offset(input logic [3:0] p);
        logic [31:0] full;
        full = 32'(BASE_ADDR) + 32'(p) * 32'(SLOT_WORDS);
        return full[9:0];
    endfunction

    assign k_legal  = (k >= 3'd2) && (k <= 3'd4);
    assign accept   = (state_q == S_IDLE) && start && k_legal;
    assign last_p   = mode_q ? {k_q, 1'b0} : ({k_q, 1'b0} - 4'd1);
    assign poly_idx = p_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mode_d  = mode_q;
        k_d     = k_q;
        eta3_d  = eta3_q;
        seed_d  = seed_q;
        nb_d    = nb_q;
`ifdef CBD_SCHED_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CLR;
                    p_d     = 4'd0;
                    mode_d  = mode;
                    k_d     = k;
                    eta3_d  = eta1_is3;
                    seed_d  = seed;
                    nb_d    = nonce_base;
`ifdef CBD_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLR:  state_d = S_FIRE;
            // smp_done seen in FIRE may be stale from the last poly; ignore it.
            S_FIRE: state_d = S_WAIT;
            S_WAIT: begin
                if (smp.smp_done) begin
                    state_d = S_NEXT;
                end
`ifdef CBD_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end
`endif
            end
            S_NEXT: begin
                if (p_q == last_p) begin
                    state_d = S_FIN;
                end else begin
                    p_d     = p_q + 4'd1;
                    state_d = S_CLR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef CBD_SCHED_TIMEOUT_EN
        if (state_d == S_CLR)
            cnt_d = '0;
        else if (state_q == S_WAIT)
            cnt_d = cnt_q + 1'b1;
`endif

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register.
        smp_active_d = (state_d == S_FIRE) || (state_d == S_WAIT);
        smp_rst_d    = !smp_active_d;
        busy_d       = (state_d == S_CLR) || (state_d == S_FIRE) ||
                       (state_d == S_WAIT) || (state_d == S_NEXT);
        done_d       = (state_d == S_FIN);

        smp_M_d      = smp.smp_M;
        n_num_d      = smp.smp_n_num;
        offset_d     = smp.smp_offset;
        if (state_d == S_CLR) begin
            smp_M_d  = {nb_d + {4'd0, p_d}, seed_d};
            n_num_d  = eta_code(mode_d, k_d, eta3_d, p_d);
            offset_d = slot_offset(p_d);
        end
    end

    // state / output register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            p_q            <= '0;
            mode_q         <= 1'b0;
            k_q            <= '0;
            eta3_q         <= 1'b0;
            seed_q         <= '0;
            nb_q           <= '0;
            smp.smp_M      <= '0;
            smp.smp_n_num  <= '0;
            smp.smp_offset <= '0;
            smp.smp_active <= 1'b0;
            smp.smp_rst    <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef CBD_SCHED_TIMEOUT_EN
            cnt_q          <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            mode_q         <= mode_d;
            k_q            <= k_d;
            eta3_q         <= eta3_d;
            seed_q         <= seed_d;
            nb_q           <= nb_d;
            smp.smp_M      <= smp_M_d;
            smp.smp_n_num  <= n_num_d;
            smp.smp_offset <= offset_d;
            smp.smp_active <= smp_active_d;
            smp.smp_rst    <= smp_rst_d;
            busy           <= busy_d;
            done           <= done_d;
`ifdef CBD_SCHED_TIMEOUT_EN
            cnt_q          <= cnt_d;
            err_q          <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_cbd_sample_scheduler.sv
// ----------------------------------------------------------------------------
// tb_cbd_sample_scheduler
// Bench for cbd_sample_scheduler with a behavioural sampler, a bus monitor and
// a reference model of the polynomial batch built from plain arithmetic.
// ----------------------------------------------------------------------------
module tb_cbd_sample_scheduler;
    localparam int BASE = 0;
    localparam int SLOT = 32;
    localparam int TMO  = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   k = 3'd2;
    logic         eta1_is3 = 1'b0;
    logic [255:0] seed = '0;
    logic [7:0]   nonce_base = '0;
    logic         busy, done, err;
    logic [3:0]   poly_idx;

    int errors = 0;
    int checks = 0;

    cbd_sample_scheduler_if smp();

    cbd_sample_scheduler #(
        .BASE_ADDR(BASE), .SLOT_WORDS(SLOT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k(k),
        .eta1_is3(eta1_is3), .seed(seed), .nonce_base(nonce_base),
        .smp(smp), .busy(busy), .done(done), .poly_idx(poly_idx), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural sampler: finishes samp_lat cycles after being fired,
    // holds its done flag until it is reset.
    int   samp_lat = 2;
    bit   force_fire = 1'b0;
    bit   stuck_low = 1'b0;
    int   samp_cnt = 0;
    logic samp_done_r = 1'b0;
    logic act_d1 = 1'b0;

    always @(posedge clk) begin
        act_d1 <= smp.smp_active;
        if (smp.smp_rst) begin
            samp_cnt    <= 0;
            samp_done_r <= 1'b0;
        end else if (smp.smp_active && !stuck_low) begin
            if (samp_cnt >= samp_lat) samp_done_r <= 1'b1;
            else                      samp_cnt    <= samp_cnt + 1;
        end
    end

    assign smp.smp_done = stuck_low ? 1'b0 :
                          (samp_done_r | (force_fire & smp.smp_active & ~act_d1));

    // Bus monitor: records every fire and simple bus-level statistics.
    logic [255:0] q_seed[$];
    logic [7:0]   q_nonce[$];
    logic [1:0]   q_n[$];
    logic [9:0]   q_off[$];
    logic [3:0]   q_idx[$];
    int           q_gap[$];
    int           q_len[$];
    int           done_cnt = 0, stab_viol = 0, premature = 0;
    int           rst_run = 0, act_run = 0;
    logic         prev_act = 1'b0, last_dn = 1'b0;
    logic [263:0] hold_M;
    logic [1:0]   hold_n;
    logic [9:0]   hold_off;

    always @(negedge clk) begin
        if (smp.smp_active) begin
            if (!prev_act) begin
                q_seed.push_back(smp.smp_M[255:0]);
                q_nonce.push_back(smp.smp_M[263:256]);
                q_n.push_back(smp.smp_n_num);
                q_off.push_back(smp.smp_offset);
                q_idx.push_back(poly_idx);
                q_gap.push_back(rst_run);
                hold_M   = smp.smp_M;
                hold_n   = smp.smp_n_num;
                hold_off = smp.smp_offset;
                act_run  = 0;
            end else if (smp.smp_M != hold_M || smp.smp_n_num != hold_n ||
                         smp.smp_offset != hold_off) begin
                stab_viol++;
            end
            act_run++;
            last_dn = samp_done_r;
        end else if (prev_act) begin
            q_len.push_back(act_run);
            if (!last_dn) premature++;
        end
        if (smp.smp_rst) rst_run++;
        else             rst_run = 0;
        if (done) done_cnt++;
        prev_act = smp.smp_active;
    end

    // Reference model of one batch.
    function automatic int model_n(input bit m, input int kk);
        return m ? 2 * kk + 1 : 2 * kk;
    endfunction

    function automatic logic [7:0] model_nonce(input int nb, input int p);
        return 8'((nb + p) % 256);
    endfunction

    function automatic logic [9:0] model_off(input int p);
        return 10'((BASE + p * SLOT) % 1024);
    endfunction

    function automatic logic [1:0] model_eta(input bit m, input int kk, input bit e3, input int p);
        if (m && p >= kk) return 2'd2;
        return e3 ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [255:0] rand_seed();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    // Drives one start pulse, then scrambles the inputs to prove they were captured.
    task automatic start_batch(input bit m, input logic [2:0] kk, input bit e3,
                               input logic [7:0] nb, input logic [255:0] sd);
        @(negedge clk);
        mode = m; k = kk; eta1_is3 = e3; nonce_base = nb; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m; k = 3'($urandom_range(0, 7)); eta1_is3 = ~e3;
        nonce_base = 8'($urandom()); seed = rand_seed();
    endtask

    task automatic wait_done(input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (smp.smp_rst !== 1'b1) begin errors++; $display("FAIL rst_smp_rst: got %b want 1", smp.smp_rst); end
        checks++; if (smp.smp_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", smp.smp_active); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (poly_idx !== 4'd0) begin errors++; $display("FAIL rst_poly_idx: got %0d want 0", poly_idx); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (smp.smp_M !== 264'd0 || smp.smp_n_num !== 2'd0 || smp.smp_offset !== 10'd0) begin
            errors++; $display("FAIL rst_bus: got n_num=%0d off=%0d want 0", smp.smp_n_num, smp.smp_offset);
        end
    endtask

    // Directed batches from the plan followed by randomized configurations.
    task automatic test_batches();
        bit m, e3, hit;
        int kk, nb, n, base, d0, s0, p0;
        logic [255:0] sd;
        for (int t = 0; t < 9; t++) begin
            case (t)
                0:       begin m = 0; kk = 3; e3 = 0; nb = 0;     end
                1:       begin m = 1; kk = 2; e3 = 1; nb = 0;     end
                2:       begin m = 0; kk = 2; e3 = 0; nb = 8'hFE; end
                default: begin
                    m = 1'($urandom_range(0, 1)); kk = $urandom_range(2, 4);
                    e3 = 1'($urandom_range(0, 1)); nb = $urandom_range(0, 255);
                end
            endcase
            sd = rand_seed();
            samp_lat = $urandom_range(1, 5);
            n = model_n(m, kk);
            base = q_nonce.size(); d0 = done_cnt; s0 = stab_viol; p0 = premature;
            start_batch(m, 3'(kk), e3, 8'(nb), sd);
            wait_done(500, hit);
            checks++; if (hit !== 1'b1) begin errors++; $display("FAIL batch%0d_done_seen: got 0 want 1", t); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL batch%0d_busy_fin: got %b want 0", t, busy); end
            checks++; if (q_nonce.size() - base != n) begin
                errors++; $display("FAIL batch%0d_poly_count: got %0d want %0d", t, q_nonce.size() - base, n);
            end
            for (int p = 0; p < n && base + p < q_nonce.size(); p++) begin
                checks++; if (q_nonce[base+p] !== model_nonce(nb, p)) begin
                    errors++; $display("FAIL batch%0d_nonce p%0d: got %h want %h", t, p, q_nonce[base+p], model_nonce(nb, p));
                end
                checks++; if (q_seed[base+p] !== sd) begin
                    errors++; $display("FAIL batch%0d_seed p%0d: got %h want %h", t, p, q_seed[base+p][31:0], sd[31:0]);
                end
                checks++; if (q_n[base+p] !== model_eta(m, kk, e3, p)) begin
                    errors++; $display("FAIL batch%0d_n_num p%0d: got %0d want %0d", t, p, q_n[base+p], model_eta(m, kk, e3, p));
                end
                checks++; if (q_off[base+p] !== model_off(p)) begin
                    errors++; $display("FAIL batch%0d_offset p%0d: got %0d want %0d", t, p, q_off[base+p], model_off(p));
                end
                checks++; if (q_idx[base+p] !== 4'(p)) begin
                    errors++; $display("FAIL batch%0d_poly_idx p%0d: got %0d want %0d", t, p, q_idx[base+p], p);
                end
                if (p > 0) begin
                    checks++; if (q_gap[base+p] < 2) begin
                        errors++; $display("FAIL batch%0d_rst_gap p%0d: got %0d want >=2", t, p, q_gap[base+p]);
                    end
                end
            end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL batch%0d_done_width: got %b want 0", t, done); end
            checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL batch%0d_done_pulses: got %0d want 1", t, done_cnt - d0); end
            checks++; if (stab_viol != s0) begin errors++; $display("FAIL batch%0d_bus_stable: got %0d changes want 0", t, stab_viol - s0); end
            checks++; if (premature != p0) begin errors++; $display("FAIL batch%0d_early_advance: got %0d want 0", t, premature - p0); end
        end
    endtask

    // start pulsed in WAIT of poly 1 and smp_done high during every FIRE.
    task automatic test_start_during_wait();
        bit hit, found;
        int base, d0, p0, n;
        logic [255:0] sd;
        sd = rand_seed();
        samp_lat = 4;
        force_fire = 1'b1;
        n = model_n(1, 3);
        base = q_nonce.size(); d0 = done_cnt; p0 = premature;
        start_batch(1'b1, 3'd3, 1'b0, 8'h40, sd);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (poly_idx == 4'd1 && smp.smp_active && act_d1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL sdw_reach_wait: got 0 want 1"); end
        mode = 1'b0; k = 3'd4; nonce_base = 8'h99; seed = rand_seed(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500, hit);
        force_fire = 1'b0;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL sdw_done_seen: got 0 want 1"); end
        checks++; if (q_nonce.size() - base != n) begin
            errors++; $display("FAIL sdw_poly_count: got %0d want %0d", q_nonce.size() - base, n);
        end
        for (int p = 0; p < n && base + p < q_nonce.size(); p++) begin
            checks++; if (q_nonce[base+p] !== model_nonce(8'h40, p) || q_seed[base+p] !== sd) begin
                errors++; $display("FAIL sdw_msg p%0d: got nonce %h want %h", p, q_nonce[base+p], model_nonce(8'h40, p));
            end
        end
        @(negedge clk);
        checks++; if (premature != p0) begin errors++; $display("FAIL sdw_early_advance: got %0d want 0", premature - p0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL sdw_done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_illegal_k();
        int base;
        logic [2:0] bad[5];
        bad = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            base = q_nonce.size();
            start_batch(1'($urandom_range(0, 1)), bad[i], 1'b0, 8'h10, rand_seed());
            repeat (8) @(negedge clk);
            checks++; if (busy !== 1'b0 || q_nonce.size() != base) begin
                errors++; $display("FAIL illegal_k%0d: got busy=%b fires=%0d want busy=0 fires=0", bad[i], busy, q_nonce.size() - base);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit hit, found;
        int base, d0;
        samp_lat = 5;
        d0 = done_cnt;
        start_batch(1'b0, 3'd3, 1'b0, 8'h20, rand_seed());
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (poly_idx == 4'd2 && smp.smp_active && act_d1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL mrst_reach_wait: got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || smp.smp_rst !== 1'b1 || smp.smp_active !== 1'b0) begin
            errors++; $display("FAIL mrst_idle: got busy=%b smp_rst=%b active=%b want 0 1 0", busy, smp.smp_rst, smp.smp_active);
        end
        checks++; if (poly_idx !== 4'd0 || err !== 1'b0) begin
            errors++; $display("FAIL mrst_regs: got poly_idx=%0d err=%b want 0 0", poly_idx, err);
        end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL mrst_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        base = q_nonce.size();
        start_batch(1'b0, 3'd2, 1'b1, 8'h30, rand_seed());
        wait_done(500, hit);
        checks++; if (hit !== 1'b1 || q_nonce.size() - base != 4) begin
            errors++; $display("FAIL mrst_restart_count: got %0d want 4", q_nonce.size() - base);
        end
        checks++; if (q_nonce.size() > base && (q_idx[base] !== 4'd0 || q_nonce[base] !== 8'h30)) begin
            errors++; $display("FAIL mrst_restart_p0: got idx=%0d nonce=%h want 0 30", q_idx[base], q_nonce[base]);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit hit;
        int base, d0;
        base = q_nonce.size(); d0 = done_cnt;
        stuck_low = 1'b1;
        start_batch(1'b1, 3'd2, 1'b0, 8'h00, rand_seed());
`ifdef CBD_SCHED_TIMEOUT_EN
        wait_done(200, hit);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL tmo_done_seen: got 0 want 1"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b want 1", err); end
        checks++; if (q_len.size() == 0 || q_len[q_len.size()-1] != TMO + 1) begin
            errors++; $display("FAIL tmo_active_len: got %0d want %0d", (q_len.size() == 0) ? 0 : q_len[q_len.size()-1], TMO + 1);
        end
        repeat (10) @(negedge clk);
        checks++; if (q_nonce.size() - base != 1) begin
            errors++; $display("FAIL tmo_skip_rest: got %0d fires want 1", q_nonce.size() - base);
        end
        checks++; if (err !== 1'b1 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL tmo_sticky: got err=%b pulses=%0d want 1 1", err, done_cnt - d0);
        end
        stuck_low = 1'b0;
        samp_lat = 2;
        start_batch(1'b0, 3'd2, 1'b0, 8'h05, rand_seed());
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b want 0", err); end
        wait_done(500, hit);
        checks++; if (hit !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL tmo_clean_batch: got done=%b err=%b want 1 0", hit, err);
        end
        @(negedge clk);
`else
        repeat (60) @(negedge clk);
        checks++; if (busy !== 1'b1 || smp.smp_active !== 1'b1) begin
            errors++; $display("FAIL nowd_still_wait: got busy=%b active=%b want 1 1", busy, smp.smp_active);
        end
        checks++; if (err !== 1'b0 || done_cnt != d0 || q_nonce.size() - base != 1) begin
            errors++; $display("FAIL nowd_no_abort: got err=%b pulses=%0d fires=%0d want 0 0 1", err, done_cnt - d0, q_nonce.size() - base);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stuck_low = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowd_recover: got busy=%b want 0", busy); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_batches();
        test_start_during_wait();
        test_illegal_k();
        test_mid_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
